lsu_align: RTL

- Load/store alignment unit between the pipeline MEM stage and the word-only data port of the unified memory.
- Loads: selects the byte or halfword from the addressed word, then sign- or zero-extends it.
- Stores: word stores go straight through; byte and halfword stores use a read-modify-write (RMW) sequence, because the memory writes whole words only.
- Flags misaligned accesses and illegal funct3 codes, and never touches memory for them.

---
 rtl/lsu_align.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lsu_align.sv
// lsu_align: load/store alignment between the MEM stage and a word-only memory.
// Sub-word stores are read-modify-write; misaligned/illegal requests error out.
//   clk, rst          : clock, async active-high reset
//   req_*             : MEM-stage request (valid/ready, we, funct3, addr, wdata)
//   resp_*            : one-cycle completion pulse with load data and error flag
//   dmem_*            : word memory port (addr, ren, comb. rdata, wen, wdata)
module lsu_align #(
   parameter int unsigned RMW_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic [31:0] dmem_addr_o,
   output logic        dmem_ren_o,
   input  logic [31:0] dmem_rdata_i,
   output logic        dmem_wen_o,
   output logic [31:0] dmem_wdata_o
);

   typedef enum logic {IDLE, MERGE} state_t;

   state_t      state;
   logic [31:0] l_addr;
   logic [15:0] l_wdata;
   logic [31:0] mbuf;
   logic        l_half;

   logic        sz_b, sz_h, sz_w;
   logic        mis, ill, no_rmw, err;
   logic        accept, go, word_st, sub_st;
   logic [7:0]  bsel;
   logic [15:0] hsel;
   logic [31:0] ld_data, mword;

   assign req_ready_o = (state == IDLE);

   always_comb begin
      sz_b    = (req_funct3_i[1:0] == 2'd0);
      sz_h    = (req_funct3_i[1:0] == 2'd1);
      sz_w    = (req_funct3_i[1:0] == 2'd2);
      mis     = (sz_w & (req_addr_i[1:0] != 2'b00)) | (sz_h & req_addr_i[0]);
      // loads: 3 and 6/7 are undefined; stores: only 0..2
      ill     = req_we_i ? (req_funct3_i > 3'd2)
                         : ((req_funct3_i[1:0] == 2'd3) |
                            (req_funct3_i[2] & req_funct3_i[1]));
      no_rmw  = req_we_i & ~sz_w & (RMW_EN == 0);
      err     = mis | ill | no_rmw;
      accept  = req_valid_i & req_ready_o & ~rst;
      go      = accept & ~err;
      word_st = go & req_we_i & sz_w;
      sub_st  = go & req_we_i & ~sz_w;
   end

   always_comb begin
      bsel = dmem_rdata_i[{req_addr_i[1:0], 3'b000} +: 8];
      hsel = req_addr_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      unique case (req_funct3_i)
         3'd0:    ld_data = {{24{bsel[7]}}, bsel};
         3'd1:    ld_data = {{16{hsel[15]}}, hsel};
         3'd4:    ld_data = {24'h0, bsel};
         3'd5:    ld_data = {16'h0, hsel};
         default: ld_data = dmem_rdata_i;
      endcase
   end

   // Splice the latched store lane into the word read at accept.
   always_comb begin
      mword = mbuf;
      if (l_half)
         mword[{l_addr[1], 4'b0000} +: 16] = l_wdata;
      else
         mword[{l_addr[1:0], 3'b000} +: 8] = l_wdata[7:0];
   end

   // Memory port is combinational so a load reads in its accept cycle;
   // gating with rst makes an in-flight merge write drop immediately.
   always_comb begin
      dmem_ren_o   = go & ~(req_we_i & sz_w);
      dmem_wen_o   = ~rst & ((state == MERGE) | word_st);
      dmem_addr_o  = 32'h0;
      dmem_wdata_o = 32'h0;
      if (!rst) begin
         if (state == MERGE) begin
            dmem_addr_o  = {l_addr[31:2], 2'b00};
            dmem_wdata_o = mword;
         end else begin
            dmem_addr_o  = {req_addr_i[31:2], 2'b00};
            if (word_st)
               dmem_wdata_o = req_wdata_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= 32'h0;
         resp_err_o   <= 1'b0;
         l_addr       <= 32'h0;
         l_wdata      <= 16'h0;
         l_half       <= 1'b0;
         mbuf         <= 32'h0;
      end else begin
         resp_valid_o <= 1'b0;
         resp_rdata_o <= 32'h0;
         resp_err_o   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (err) begin
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b1;
                  end else if (!req_we_i) begin
                     resp_valid_o <= 1'b1;
                     resp_rdata_o <= ld_data;
                  end else if (sub_st) begin
                     state   <= MERGE;
                     l_addr  <= req_addr_i;
                     l_wdata <= req_wdata_i[15:0];
                     l_half  <= sz_h;
                     mbuf    <= dmem_rdata_i;
                  end else begin
                     resp_valid_o <= 1'b1;
                  end
               end
            end
            MERGE: begin
               state        <= IDLE;
               resp_valid_o <= 1'b1;
            end
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = sz_b;

endmodule
